alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the single-cycle ALU control decode: decodes aluOp/funct3/funct7 into a 4-bit
//  ALU control code and executes the operation on XLEN-bit operands. It also runs an optional iterative
//  shift-add multiplier (RV32M MUL) and uses a valid/ready handshake at input and output.
//  Sits between register-read and writeback in the multi-cycle datapath.
// PARAMETERS
//  XLEN    32  operand/result width (>=8, power of 2)
//  MUL_EN  1   1: MUL (funct7=0000001, funct3=000) supported; 0: decoded as illegal
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  in_valid   in   1     operation request valid
//  in_ready   out  1     unit can accept request (high only in IDLE)
//  aluOp      in   2     00 load/store, 01 branch, 10 R-type, 11 I-type
//  funct3     in   3     instruction funct3
//  funct7     in   7     instruction funct7 (I-type: imm[11:5])
//  op_a       in   XLEN  operand A
//  op_b       in   XLEN  operand B (shift amount = op_b[log2(XLEN)-1:0])
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  registered result
//  zero       out  1     registered (result == 0)
//  illegal    out  1     registered: decode illegal, result forced 0
//  alu_ctl    out  4     registered control code of the accepted op
// BEHAVIOUR
//  Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010.
//  Decode: aluOp 00 -> ADD (any funct3).
//   aluOp 01 -> funct3 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 illegal.
//   aluOp 10, f7=0000000 -> f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
//   aluOp 10, f7=0100000 -> f3 000 SUB, 101 SRA. aluOp 10, f7=0000001, f3 000 -> MUL if MUL_EN.
//   All other aluOp 10 combinations are illegal.
//   aluOp 11: as R-type with f7 ignored, except f3 001 needs f7=0000000 and f3 101 needs f7 0000000 (SRL) or 0100000 (SRA).
//   Also for aluOp 11, f3 000 is always ADD (no SUB).
//  SLT is signed and SLTU unsigned; both give result 0 or 1. MUL returns the low XLEN bits of the product (sign-agnostic).
//  FSM: IDLE -> (in_valid & in_ready) -> EXEC, or MUL if the decode is MUL.
//   EXEC -> DONE after 1 clock. MUL -> DONE after XLEN clocks: one bit of op_b per clock, LSB first, with shifted op_a added.
//   DONE -> IDLE on out_ready.
//  Operands and decode are captured on the accept edge; later input changes do not affect the op in flight.
//  Latency: out_valid rises 2 clocks after the accept edge for single-cycle and illegal ops, and XLEN+1 clocks after it for MUL.
//  in_ready = (state==IDLE). No overlap: a new request is accepted at the earliest 1 clock after the out handshake.
//  out_valid = (state==DONE). result/zero/illegal/alu_ctl are stable while out_valid=1 and out_ready=0.
//  Illegal op: EXEC path, result=0, zero=1, illegal=1, alu_ctl=0000.
//  in_valid outside IDLE is ignored (not queued).
//  Reset (async, any state, including mid-MUL): state IDLE, out_valid 0, result 0, zero 0, illegal 0, alu_ctl 0000.
//   Accumulators are cleared. in_ready is 1 once reset deasserts.
//  Shifts by 0 return op_a unchanged; SRA replicates op_a[XLEN-1]; all arithmetic wraps modulo 2^XLEN.
// TESTING (XLEN=32 unless stated)
//  1. aluOp=10 f3=000 f7=0 a=5 b=7, out_ready=1 -> out_valid 2 clk after accept, result=12, zero=0, alu_ctl=0010.
//  2. aluOp=01 f3=000 a=b=0x1234 -> result=0, zero=1, alu_ctl=0110; f3=110 a=1 b=0xFFFFFFFF -> result=1 (SLTU).
//  3. aluOp=10 f3=101 f7=0100000 a=0x80000000 b=4 -> result=0xF8000000; same with f7=0 -> 0x08000000.
//  4. MUL a=0xFFFFFFFF b=3 -> result=0xFFFFFFFD exactly 33 clk after accept; in_ready=0 throughout.
//     With MUL_EN=0 the same request gives illegal=1.
//  5. Hold out_ready=0 for 5 clk with in_valid=1 and changing inputs -> result/out_valid stable, no new accept.
//     Then out_ready=1 -> IDLE, and the next request is accepted 1 clk later.
//  6. aluOp=10 f3=000 f7=1111111 -> illegal=1, result=0. Assert reset 10 clk into a MUL -> out_valid=0 immediately.
//     in_ready=1 after reset release, and the next ADD completes correctly.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execute stage: decodes aluOp/funct3/funct7 to a 4-bit control code and runs it on XLEN-bit operands.
// Latency: out_valid 2 clocks after the accept cycle for single-cycle/illegal ops, XLEN+1 clocks for MUL.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, reset (async active-high)
//   in_valid/in_ready   request handshake; aluOp, funct3, funct7, op_a, op_b captured on accept
//   out_valid/out_ready result handshake; result, zero, illegal, alu_ctl registered, stable while held
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      alu_ctl
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [3:0]      ctl_q, ctl_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d, illegal_q, illegal_d;
    logic [3:0]      alu_ctl_q, alu_ctl_d;

    logic [3:0]      base_ctl, dec_ctl;
    logic            dec_ill;
    logic [XLEN-1:0] alu_res, acc_step;
    logic [SHW-1:0]  shamt;

    // R-type table for funct7=0000000; I-type reuses it (funct3 000 stays ADD).
    always_comb begin
        base_ctl = C_ADD;
        case (funct3)
            3'b000:  base_ctl = C_ADD;
            3'b001:  base_ctl = C_SLL;
            3'b010:  base_ctl = C_SLT;
            3'b011:  base_ctl = C_SLTU;
            3'b100:  base_ctl = C_XOR;
            3'b101:  base_ctl = C_SRL;
            3'b110:  base_ctl = C_OR;
            default: base_ctl = C_AND;
        endcase
    end

    always_comb begin
        dec_ctl = C_ADD;
        dec_ill = 1'b0;
        case (aluOp)
            2'b00: dec_ctl = C_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: dec_ctl = C_SUB;
                    3'b100, 3'b101: dec_ctl = C_SLT;
                    3'b110, 3'b111: dec_ctl = C_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (funct7 == 7'b0000000)
                    dec_ctl = base_ctl;
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    dec_ctl = C_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    dec_ctl = C_SRA;
                else if (funct7 == 7'b0000001 && funct3 == 3'b000 && MUL_EN)
                    dec_ctl = C_MUL;
                else
                    dec_ill = 1'b1;
            end
            default: begin
                // I-type: funct7 is immediate bits except for the shift encodings.
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) dec_ctl = C_SLL;
                    else                      dec_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000)      dec_ctl = C_SRL;
                    else if (funct7 == 7'b0100000) dec_ctl = C_SRA;
                    else                           dec_ill = 1'b1;
                end else begin
                    dec_ctl = base_ctl;
                end
            end
        endcase
        if (dec_ill) dec_ctl = C_AND;
    end

    assign shamt = b_q[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ctl_q)
            C_AND:  alu_res = a_q & b_q;
            C_OR:   alu_res = a_q | b_q;
            C_ADD:  alu_res = a_q + b_q;
            C_XOR:  alu_res = a_q ^ b_q;
            C_SLL:  alu_res = a_q << shamt;
            C_SRL:  alu_res = a_q >> shamt;
            C_SUB:  alu_res = a_q - b_q;
            C_SRA:  alu_res = XLEN'($signed(a_q) >>> shamt);
            C_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            C_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            default: alu_res = '0;
        endcase
    end

    // Shift-add: a_q is the multiplicand shifted left, b_q the multiplier shifted right.
    assign acc_step = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ctl_d     = ctl_q;
        ill_d     = ill_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        alu_ctl_d = alu_ctl_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    ctl_d   = dec_ctl;
                    ill_d   = dec_ill;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (dec_ctl == C_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d  = ill_q ? '0 : alu_res;
                zero_d    = ill_q ? 1'b1 : (alu_res == '0);
                illegal_d = ill_q;
                alu_ctl_d = ctl_q;
                state_d   = S_DONE;
            end
            S_MUL: begin
                acc_d = acc_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d  = acc_step;
                    zero_d    = (acc_step == '0);
                    illegal_d = 1'b0;
                    alu_ctl_d = C_MUL;
                    state_d   = S_DONE;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ctl_q     <= C_AND;
            ill_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            alu_ctl_q <= C_AND;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ctl_q     <= ctl_d;
            ill_q     <= ill_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            alu_ctl_q <= alu_ctl_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign alu_ctl   = alu_ctl_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed checks of alu_exec_unit against a mnemonic-level reference model.
// Latency: n/a (bench).
// Backpressure: out_ready randomised, held low, or held high per phase.
module tb_alu_exec_unit;
    logic        clk, reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  aluOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a, op_b, result;
    logic        zero, illegal;
    logic [3:0]  alu_ctl;

    logic        in_valid2, in_ready2, out_valid2, zero2, illegal2;
    logic [31:0] result2;
    logic [3:0]  alu_ctl2;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .alu_ctl(alu_ctl));

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid2), .out_ready(1'b1), .result(result2),
        .zero(zero2), .illegal(illegal2), .alu_ctl(alu_ctl2));

    typedef struct {
        logic [31:0] r;
        bit          il;
        logic [3:0]  c;
    } exp_t;

    exp_t  q[$];
    int    n_cmp = 0, n_fail = 0;
    int    cyc = 0, acc_cyc = 0, cur_lat = 2;
    bit    pending = 0;
    int    rdy_mode = 0;
    string rnames[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 0;
                default: out_ready = 1;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: resolve the instruction to a mnemonic, then evaluate it arithmetically.
    function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b, input bit mul_en,
                                  output exp_t e, output int lat);
        string m;
        logic [4:0] sh;
        m  = "ILL";
        sh = b[4:0];
        case (op)
            2'd0: m = "ADD";
            2'd1: m = (f3 inside {0, 1}) ? "SUB" : (f3 inside {4, 5}) ? "SLT" :
                      (f3 inside {6, 7}) ? "SLTU" : "ILL";
            2'd2: begin
                if (f7 == 7'h00) m = rnames[f3];
                else if (f7 == 7'h20 && f3 == 0) m = "SUB";
                else if (f7 == 7'h20 && f3 == 5) m = "SRA";
                else if (f7 == 7'h01 && f3 == 0 && mul_en) m = "MUL";
            end
            default: begin
                if (f3 == 1) m = (f7 == 7'h00) ? "SLL" : "ILL";
                else if (f3 == 5) m = (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "ILL";
                else m = rnames[f3];
            end
        endcase
        e.il = (m == "ILL");
        case (m)
            "AND":  begin e.r = a & b;                        e.c = 4'd0;  end
            "OR":   begin e.r = a | b;                        e.c = 4'd1;  end
            "ADD":  begin e.r = a + b;                        e.c = 4'd2;  end
            "XOR":  begin e.r = a ^ b;                        e.c = 4'd3;  end
            "SLL":  begin e.r = a << sh;                      e.c = 4'd4;  end
            "SRL":  begin e.r = a >> sh;                      e.c = 4'd5;  end
            "SUB":  begin e.r = a - b;                        e.c = 4'd6;  end
            "SRA":  begin e.r = $signed(a) >>> sh;            e.c = 4'd7;  end
            "SLT":  begin e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.c = 4'd8; end
            "SLTU": begin e.r = (a < b) ? 32'd1 : 32'd0;      e.c = 4'd9;  end
            "MUL":  begin e.r = a * b;                        e.c = 4'd10; end
            default: begin e.r = 32'd0;                       e.c = 4'd0;  end
        endcase
        lat = (m == "MUL") ? 33 : 2;
    endfunction

    // Single compare process: handshake lines every cycle, payload whenever out_valid is due.
    always @(negedge clk) begin
        if (!reset) begin
            bit exp_ov;
            exp_ov = pending && (cyc - acc_cyc + 1 >= cur_lat);
            chk("in_ready", {31'd0, in_ready}, {31'd0, !pending});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (out_valid && exp_ov && q.size() > 0) begin
                chk("result", result, q[0].r);
                chk("zero", {31'd0, zero}, {31'd0, (q[0].r == 32'd0)});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].il});
                chk("alu_ctl", {28'd0, alu_ctl}, {28'd0, q[0].c});
                if (out_ready) begin
                    void'(q.pop_front());
                    pending = 0;
                end
            end
        end
    end

    task automatic scramble();
        aluOp  = 2'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   l;
        int   t;
        aluOp = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1;
        t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        model(op, f3, f7, a, b, 1'b1, e, l);
        q.push_back(e);
        cur_lat = l;
        acc_cyc = cyc;
        pending = 1;
        in_valid = 0;
        scramble();
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && pending; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", {31'd0, pending}, 32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        int   l;
        logic [6:0] f7;
        reset = 1; in_valid = 0; in_valid2 = 0;
        aluOp = 0; funct3 = 0; funct7 = 0; op_a = 0; op_b = 0;

        // Pin the model with hand-computed values.
        model(2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 1'b1, e, l);
        chk("model_add", e.r, 32'd12);
        chk("model_add_ctl", {28'd0, e.c}, 32'd2);
        model(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 1'b1, e, l);
        chk("model_sra", e.r, 32'hF800_0000);
        model(2'b01, 3'b110, 7'h00, 32'd1, 32'hFFFF_FFFF, 1'b1, e, l);
        chk("model_sltu", e.r, 32'd1);
        model(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd3, 1'b1, e, l);
        chk("model_mul", e.r, 32'hFFFF_FFFD);
        chk("model_mul_lat", l, 33);
        model(2'b10, 3'b000, 7'h7F, 32'd9, 32'd9, 1'b1, e, l);
        chk("model_ill", {31'd0, e.il}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        @(posedge clk);
        #1;

        // MUL request on the MUL_EN=0 instance must come back illegal.
        aluOp = 2'b10; funct3 = 3'b000; funct7 = 7'h01; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
        in_valid2 = 1;
        @(posedge clk);
        #1;
        in_valid2 = 0;
        scramble();
        @(posedge clk);
        #1;
        model(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd3, 1'b0, e, l);
        chk("nomul_valid", {31'd0, out_valid2}, 32'd1);
        chk("nomul_illegal", {31'd0, illegal2}, {31'd0, e.il});
        chk("nomul_result", result2, e.r);
        chk("nomul_zero", {31'd0, zero2}, 32'd1);
        chk("nomul_ctl", {28'd0, alu_ctl2}, {28'd0, e.c});
        @(posedge clk);
        #1;
        chk("nomul_ready", {31'd0, in_ready2}, 32'd1);

        // Directed cases.
        rdy_mode = 2;
        do_op(2'b10, 3'b000, 7'h00, 32'd5, 32'd7);
        do_op(2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234);
        do_op(2'b01, 3'b110, 7'h00, 32'd1, 32'hFFFF_FFFF);
        do_op(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4);
        do_op(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4);
        do_op(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd0);
        do_op(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd3);
        do_op(2'b10, 3'b000, 7'h7F, 32'd9, 32'd9);
        do_op(2'b11, 3'b000, 7'h20, 32'd10, 32'd3);
        wait_idle();

        // Hold the result with in_valid high and inputs changing.
        rdy_mode = 1;
        do_op(2'b10, 3'b100, 7'h00, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
        for (int k = 0; k < 6; k++) begin
            scramble();
            in_valid = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        rdy_mode = 2;
        do_op(2'b00, 3'b111, 7'h00, 32'd40, 32'd2);
        wait_idle();

        // Random traffic.
        rdy_mode = 0;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            do_op(2'($urandom), 3'($urandom), f7, pick_val(), pick_val());
        end
        wait_idle();

        // Reset in the middle of a MUL.
        do_op(2'b10, 3'b000, 7'h01, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        reset = 1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        q.delete();
        pending = 0;
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_op(2'b10, 3'b000, 7'h00, 32'd100, 32'd23);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
